btb_assoc_predictor: RTL and testbench

- Parametrised set-associative branch target buffer with per-entry saturating direction counters.
- Lookup is combinational from the fetch PC, with a same-cycle prediction to the PC mux and the IF/ID latch.
- Resolved branches update the table from the MEM stage.
- A sequential invalidate engine clears the table one set per cycle, for context switch and self-modifying-code flush.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/sat_counter.sv | 22 ++
 rtl/btb_assoc_predictor.sv | 187 ++++++++++++++++++
 tb/tb_btb_assoc_predictor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types, constants and address-split helpers for the branch predictor blocks.
package bp_pkg;

    localparam int unsigned CNT_W    = 2;
    localparam int unsigned PC_MAX_W = 64;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_WEAK_T  = cnt_t'(1 << (CNT_W - 1));
    localparam cnt_t CNT_WEAK_NT = cnt_t'((1 << (CNT_W - 1)) - 1);
    localparam cnt_t CNT_MAX     = '1;

    typedef enum logic {
        IDLE,
        CLEAR
    } btb_state_t;

    // Set index: word-aligned PC bits just above the byte offset.
    function automatic logic [PC_MAX_W-1:0] idx_of(input logic [PC_MAX_W-1:0] pc,
                                                  input int unsigned idx_w);
        return (pc >> 2) & ((PC_MAX_W'(1) << idx_w) - PC_MAX_W'(1));
    endfunction

    // Tag: everything above the index; caller truncates to its tag width.
    function automatic logic [PC_MAX_W-1:0] tag_of(input logic [PC_MAX_W-1:0] pc,
                                                  input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-value logic; never wraps at either end.
module sat_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic [CNT_W-1:0] cur_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] nxt_o
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    always_comb begin
        nxt_o = cur_i;
        if (inc_i && (cur_i != MAX_VAL)) begin
            nxt_o = cur_i + CNT_W'(1);
        end else if (dec_i && (cur_i != '0)) begin
            nxt_o = cur_i - CNT_W'(1);
        end
    end

endmodule

// File: rtl/btb_assoc_predictor.sv
// Set-associative BTB with per-entry direction counters, combinational lookup,
// MEM-stage update and a one-set-per-cycle invalidate engine.
module btb_assoc_predictor #(
    parameter int unsigned SETS  = 4,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned PC_W  = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            hit,
    output logic            predict_taken,
    output logic [PC_W-1:0] target,
    input  logic            update_en,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic [PC_W-1:0] update_target,
    input  logic            inval_req,
    output logic            busy
);

    import bp_pkg::*;

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;
    localparam int unsigned TGT_W = PC_W - 2;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [CNT_W-1:0] W_T  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] W_NT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic             valid_q [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [TGT_W-1:0] tgt_q   [SETS][WAYS];
    logic [CNT_W-1:0] cnt_q   [SETS][WAYS];
    logic [WAY_W-1:0] rr_q    [SETS];

    btb_state_t       state_q, state_d;
    logic [IDX_W-1:0] set_ptr_q, set_ptr_d;

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic [WAY_W-1:0] l_way;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [WAY_W-1:0] u_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] rr_adv;
    logic [CNT_W-1:0] cnt_nxt;
    logic             upd_fire;

    logic [1:0]       unused_tgt_lsb;
    assign unused_tgt_lsb = update_target[1:0];

    assign busy = (state_q == CLEAR);

    // Lookup: descending scan so the lowest matching way wins.
    always_comb begin
        l_idx = IDX_W'(idx_of(PC_MAX_W'(lookup_pc), IDX_W));
        l_tag = TAG_W'(tag_of(PC_MAX_W'(lookup_pc), IDX_W));
        l_hit = 1'b0;
        l_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag)) begin
                l_hit = 1'b1;
                l_way = WAY_W'(w);
            end
        end
    end

    assign hit           = l_hit & ~busy;
    assign predict_taken = hit & cnt_q[l_idx][l_way][CNT_W-1];
    assign target        = hit ? {tgt_q[l_idx][l_way], 2'b00} : '0;

    // Update side: tag match, lowest invalid way and replacement victim.
    always_comb begin
        u_idx     = IDX_W'(idx_of(PC_MAX_W'(update_pc), IDX_W));
        u_tag     = TAG_W'(tag_of(PC_MAX_W'(update_pc), IDX_W));
        u_hit     = 1'b0;
        u_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!valid_q[u_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : rr_q[u_idx];
        if (WAYS == 1 || rr_q[u_idx] == WAY_W'(WAYS - 1)) begin
            rr_adv = '0;
        end else begin
            rr_adv = rr_q[u_idx] + WAY_W'(1);
        end
    end

    assign upd_fire = update_en & ~busy & ~inval_req;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .cur_i(cnt_q[u_idx][u_way]),
        .inc_i(update_taken),
        .dec_i(~update_taken),
        .nxt_o(cnt_nxt)
    );

    // Table storage: reset wipes everything, CLEAR wipes one set per cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    cnt_q[s][w]   <= W_NT;
                end
            end
        end else if (busy) begin
            rr_q[set_ptr_q] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[set_ptr_q][w] <= 1'b0;
                cnt_q[set_ptr_q][w]   <= W_NT;
            end
        end else if (upd_fire) begin
            if (u_hit) begin
                cnt_q[u_idx][u_way] <= cnt_nxt;
                if (update_taken) begin
                    tgt_q[u_idx][u_way] <= update_target[PC_W-1:2];
                end
            end else if (update_taken) begin
                valid_q[u_idx][victim] <= 1'b1;
                tag_q[u_idx][victim]   <= u_tag;
                tgt_q[u_idx][victim]   <= update_target[PC_W-1:2];
                cnt_q[u_idx][victim]   <= W_T;
                if (!inv_found) begin
                    rr_q[u_idx] <= rr_adv;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            set_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            set_ptr_q <= set_ptr_d;
        end
    end

    // Invalidate sequencer; requests arriving mid-sweep are ignored.
    always_comb begin
        state_d   = state_q;
        set_ptr_d = set_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (inval_req) begin
                    state_d   = CLEAR;
                    set_ptr_d = '0;
                end
            end
            CLEAR: begin
                set_ptr_d = set_ptr_q + IDX_W'(1);
                if (set_ptr_q == IDX_W'(SETS - 1)) begin
                    state_d   = IDLE;
                    set_ptr_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                set_ptr_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btb_assoc_predictor.sv
// Directed bench for btb_assoc_predictor at SETS=4, WAYS=2, CNT_W=2, PC_W=32.
module tb_btb_assoc_predictor;

    logic        CLK;
    logic        RST;
    logic [31:0] lookup_pc;
    logic        hit;
    logic        predict_taken;
    logic [31:0] target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        inval_req;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    btb_assoc_predictor #(
        .SETS (4),
        .WAYS (2),
        .CNT_W(2),
        .PC_W (32)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .lookup_pc    (lookup_pc),
        .hit          (hit),
        .predict_taken(predict_taken),
        .target       (target),
        .update_en    (update_en),
        .update_pc    (update_pc),
        .update_taken (update_taken),
        .update_target(update_target),
        .inval_req    (inval_req),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic h,
                        input logic pt, input logic [31:0] tg);
        lookup_pc = pc;
        #1;
        check_eq({tag, ".hit"}, 32'(hit), 32'(h));
        check_eq({tag, ".pt"},  32'(predict_taken), 32'(pt));
        check_eq({tag, ".tgt"}, target, tg);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        update_en     = 1'b1;
        update_pc     = pc;
        update_taken  = tk;
        update_target = tg;
        cyc();
        update_en     = 1'b0;
    endtask

    initial begin
        RST = 1'b1; lookup_pc = '0; update_en = 1'b0; update_pc = '0;
        update_taken = 1'b0; update_target = '0; inval_req = 1'b0;
        @(negedge CLK);
        cyc();
        RST = 1'b0;

        // Reset state
        look("rst", 32'h40, 1'b0, 1'b0, 32'h0);
        check_eq("rst.busy", 32'(busy), 32'h0);

        // Allocate, then walk the counter through both saturation ends
        upd(32'h40, 1'b1, 32'h100);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h999);
        look("nt1", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b0, 32'h999);
        look("nt2", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b0, 32'h999);
        look("nt3", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b1, 32'h100);
        look("t1", 32'h40, 1'b1, 1'b0, 32'h100);
        upd(32'h40, 1'b1, 32'h104);
        look("t2", 32'h40, 1'b1, 1'b1, 32'h104);

        // Replacement in set 0
        upd(32'h80, 1'b1, 32'h200);
        upd(32'hC0, 1'b1, 32'h300);
        look("evict0.40", 32'h40, 1'b0, 1'b0, 32'h0);
        look("evict0.80", 32'h80, 1'b1, 1'b1, 32'h200);
        look("evict0.c0", 32'hC0, 1'b1, 1'b1, 32'h300);
        upd(32'h100, 1'b1, 32'h400);
        look("evict1.80",  32'h80,  1'b0, 1'b0, 32'h0);
        look("evict1.100", 32'h100, 1'b1, 1'b1, 32'h400);
        look("evict1.c0",  32'hC0,  1'b1, 1'b1, 32'h300);

        // Fill the other sets, then invalidate
        upd(32'h44, 1'b1, 32'h500);
        upd(32'h48, 1'b1, 32'h504);
        upd(32'h4C, 1'b1, 32'h508);
        look("fill.44", 32'h44, 1'b1, 1'b1, 32'h500);
        look("fill.4c", 32'h4C, 1'b1, 1'b1, 32'h508);

        inval_req = 1'b1;
        update_en = 1'b1; update_pc = 32'h50; update_taken = 1'b1; update_target = 32'h50C;
        cyc();
        inval_req = 1'b0;
        update_pc = 32'h40; update_target = 32'h510;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("inv.busy%0d", i), 32'(busy), 32'h1);
            look($sformatf("inv.force%0d", i), 32'hC0, 1'b0, 1'b0, 32'h0);
            if (i == 1) inval_req = 1'b1;
            cyc();
            inval_req = 1'b0;
        end
        update_en = 1'b0;
        check_eq("inv.done", 32'(busy), 32'h0);
        look("inv.40",  32'h40,  1'b0, 1'b0, 32'h0);
        look("inv.44",  32'h44,  1'b0, 1'b0, 32'h0);
        look("inv.48",  32'h48,  1'b0, 1'b0, 32'h0);
        look("inv.4c",  32'h4C,  1'b0, 1'b0, 32'h0);
        look("inv.c0",  32'hC0,  1'b0, 1'b0, 32'h0);
        look("inv.100", 32'h100, 1'b0, 1'b0, 32'h0);
        look("inv.50",  32'h50,  1'b0, 1'b0, 32'h0);

        // Same-cycle update and lookup; not-taken miss allocates nothing
        update_en = 1'b1; update_pc = 32'h200; update_taken = 1'b1; update_target = 32'h600;
        look("same.pre", 32'h200, 1'b0, 1'b0, 32'h0);
        cyc();
        update_en = 1'b0;
        look("same.post", 32'h200, 1'b1, 1'b1, 32'h600);
        upd(32'h300, 1'b0, 32'h700);
        look("ntmiss", 32'h300, 1'b0, 1'b0, 32'h0);

        // Reset in the second CLEAR cycle
        upd(32'h44, 1'b1, 32'h800);
        upd(32'h4C, 1'b1, 32'h804);
        inval_req = 1'b1;
        cyc();
        inval_req = 1'b0;
        cyc();
        check_eq("rstclr.busy_pre", 32'(busy), 32'h1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        check_eq("rstclr.busy", 32'(busy), 32'h0);
        look("rstclr.44",  32'h44,  1'b0, 1'b0, 32'h0);
        look("rstclr.4c",  32'h4C,  1'b0, 1'b0, 32'h0);
        look("rstclr.200", 32'h200, 1'b0, 1'b0, 32'h0);
        upd(32'h44, 1'b1, 32'h900);
        look("rstclr.reuse", 32'h44, 1'b1, 1'b1, 32'h900);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
